// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding a single downstream FIFO.
// The winner keeps the FIFO for up to MAX_BURST consecutive beats.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          locked
);

  localparam int IdxW = $clog2(NUM_REQ);
  localparam int CntW = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;

  logic              has_cand;
  logic [IdxW-1:0]   cand;
  logic              xfer;

  // (base + off) mod NUM_REQ, valid for base < NUM_REQ and off <= NUM_REQ.
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(NUM_REQ)) s = s - 32'(NUM_REQ);
    return IdxW'(s);
  endfunction

  // Walk downward so the last hit is the one nearest rr_ptr.
  always_comb begin
    has_cand = 1'b0;
    cand     = '0;
    if (state_q == StIdle) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[wrap_add(rr_ptr_q, 32'(k))]) begin
          has_cand = 1'b1;
          cand     = wrap_add(rr_ptr_q, 32'(k));
        end
      end
    end else if (req_valid[owner_q]) begin
      has_cand = 1'b1;
      cand     = owner_q;
    end
    if (!reset_n) begin
      has_cand = 1'b0;
      cand     = '0;
    end
  end

  assign xfer = has_cand & ~fifo_full;

  always_comb begin
    fifo_wr_en   = xfer;
    req_ready    = '0;
    fifo_wr_data = '0;
    if (xfer) begin
      req_ready    = NUM_REQ'(1) << cand;
      fifo_wr_data = req_data[cand*DATA_WIDTH +: DATA_WIDTH];
    end
    grant_id = cand;
    locked   = (state_q == StBurst);
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (MAX_BURST == 1) begin
            rr_ptr_d = wrap_add(cand, 1);
          end else begin
            owner_d    = cand;
            beat_cnt_d = CntW'(1);
            state_d    = StBurst;
          end
        end
      end
      StBurst: begin
        // Owner dropping valid releases the lock even while the FIFO is full.
        if (!req_valid[owner_q]) begin
          rr_ptr_d = wrap_add(owner_q, 1);
          state_d  = StIdle;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_d == CntW'(MAX_BURST)) begin
            rr_ptr_d = wrap_add(owner_q, 1);
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table through a scoreboard queue, plus
// hand-written reset-pulse and two-requester alternation sequences.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic             fifo_full;
  logic [1:0]       grant_id;
  logic             locked;

  logic [1:0]  v2;
  logic [15:0] d2;
  logic [1:0]  r2;
  logic        we2;
  logic [7:0]  wd2;
  logic        full2;
  logic [0:0]  gid2;
  logic        lk2;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_full(fifo_full), .grant_id(grant_id), .locked(locked)
  );

  fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .req_valid(v2), .req_data(d2),
    .req_ready(r2), .fifo_wr_en(we2), .fifo_wr_data(wd2),
    .fifo_full(full2), .grant_id(gid2), .locked(lk2)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] valid;
    logic       full;
    logic [3:0] ready;
    int         gid;
    logic       lk;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] ready;
    int         gid;
    logic       lk;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] dat(input int i);
    return 32'hC0DE_0000 | (32'(i) * 32'h1111);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [3:0] ready, input int gid,
                            input logic lk);
    logic [31:0] exp_data;
    exp_data = (|ready) ? dat(gid) : 32'h0;
    cmp({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(|ready));
    cmp({tag, ".ready"}, 32'(req_ready), 32'(ready));
    cmp({tag, ".grant"}, 32'(grant_id), 32'(gid));
    cmp({tag, ".locked"}, 32'(locked), 32'(lk));
    cmp({tag, ".data"}, fifo_wr_data, exp_data);
  endtask

  task automatic add(input logic rst_n, input logic [3:0] valid, input logic full,
                     input logic [3:0] ready, input int gid, input logic lk);
    vecs.push_back('{rst_n, valid, full, ready, gid, lk});
  endtask

  task automatic run_vec(input int i);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n   = vecs[i].rst_n;
    req_valid = vecs[i].valid;
    fifo_full = vecs[i].full;
    sb.push_back('{i, vecs[i].ready, vecs[i].gid, vecs[i].lk});
    @(negedge clk);
    e = sb.pop_front();
    check_main($sformatf("vec%0d", e.idx), e.ready, e.gid, e.lk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = dat(i);
    v2    = '0;
    d2    = 16'hA55A;
    full2 = 1'b0;

    // Reset holds outputs low even with all requesters valid.
    add(0, 4'b1111, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b0000, 0, 0);
    // Four-beat bursts in round-robin order.
    for (int i = 0; i < 12; i++) add(1, 4'b1111, 0, 4'(1 << (i / 4)), i / 4, (i % 4) != 0);
    // Single beat from requester 2, drop, then 1001 resumes at requester 3.
    add(1, 4'b0100, 0, 4'b0100, 2, 0);
    add(1, 4'b0000, 0, 4'b0000, 0, 1);
    add(1, 4'b1001, 0, 4'b1000, 3, 0);
    // Stall mid-burst for five cycles, then the two remaining beats.
    add(1, 4'b1001, 0, 4'b1000, 3, 1);
    for (int i = 0; i < 5; i++) add(1, 4'b1001, 1, 4'b0000, 3, 1);
    add(1, 4'b1001, 0, 4'b1000, 3, 1);
    add(1, 4'b1001, 0, 4'b1000, 3, 1);
    add(1, 4'b1001, 0, 4'b0001, 0, 0);
    // Owner 0 drops; requester 1 bursts then drops while the FIFO is full.
    add(1, 4'b0010, 0, 4'b0000, 0, 1);
    add(1, 4'b0010, 0, 4'b0010, 1, 0);
    add(1, 4'b0000, 1, 4'b0000, 0, 1);
    add(1, 4'b0110, 0, 4'b0100, 2, 0);
    // Hand off to a requester 3 burst, two beats deep.
    add(1, 4'b1000, 0, 4'b0000, 0, 1);
    add(1, 4'b1000, 0, 4'b1000, 3, 0);
    add(1, 4'b1000, 0, 4'b1000, 3, 1);

    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    // Short reset pulse between edges during the requester 3 burst.
    @(posedge clk);
    #1;
    req_valid = 4'b1000;
    #0.5;
    check_main("pre_rst", 4'b1000, 3, 1);
    #0.5;
    reset_n = 1'b0;
    #1;
    check_main("in_rst", 4'b0000, 0, 0);
    #1;
    req_valid = 4'b0000;
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 4'b1010;
    @(negedge clk);
    check_main("post_rst", 4'b0010, 1, 0);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;

    // Two requesters, single-beat grants: strict alternation, never locked.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      v2 = 2'b11;
      @(negedge clk);
      cmp($sformatf("alt%0d.grant", i), 32'(gid2), 32'(i % 2));
      cmp($sformatf("alt%0d.ready", i), 32'(r2), 32'(1 << (i % 2)));
      cmp($sformatf("alt%0d.wr_en", i), 32'(we2), 32'(1));
      cmp($sformatf("alt%0d.data", i), 32'(wd2), (i % 2 == 0) ? 32'h5A : 32'hA5);
      cmp($sformatf("alt%0d.locked", i), 32'(lk2), 32'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ SHALL be an integer, default 4: number of write requesters, range 2..8.
REQ-002 Parameter DATA_WIDTH SHALL be an integer, default 32: width of each requester's data and of fifo_wr_data.
REQ-003 Parameter MAX_BURST SHALL be an integer, default 4: maximum consecutive beats per grant, range 1..16.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  bit i set: requester i presents a beat.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  flattened; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  NUM_REQ  one-hot or zero; bit i set: requester i's beat is accepted this cycle.
REQ-009 fifo_wr_en  output  1  write strobe to the downstream fifo.
REQ-010 fifo_wr_data  output  DATA_WIDTH  data to the downstream fifo.
REQ-011 fifo_full  input  1  full flag from the downstream fifo.
REQ-012 grant_id  output  $clog2(NUM_REQ)  index of the current grant candidate; 0 when none.
REQ-013 locked  output  1  high while in the BURST state.

Function
REQ-014 The block SHALL hold state: an FSM with states IDLE and BURST, rr_ptr (index), owner (index) and beat_cnt (width $clog2(MAX_BURST)+1).
REQ-015 In IDLE, the candidate SHALL be the first requester with req_valid set, searching from rr_ptr upward with wrap from NUM_REQ-1 to 0; there is no candidate if req_valid is all zero.
REQ-016 In BURST, the candidate SHALL be owner when req_valid[owner] is 1; otherwise there is no candidate.
REQ-017 A transfer SHALL occur when a candidate exists and fifo_full is 0: fifo_wr_en=1, req_ready[candidate]=1, fifo_wr_data=req_data of the candidate.
REQ-018 All of fifo_wr_en, req_ready and fifo_wr_data SHALL be combinational in the same cycle, with zero latency from req_valid to fifo_wr_en.
REQ-019 With no transfer, fifo_wr_en SHALL be 0, req_ready SHALL be 0, and fifo_wr_data SHALL be 0.
REQ-020 When fifo_full is 1, no transfer SHALL occur, and FSM, rr_ptr, owner and beat_cnt SHALL hold, except as stated in REQ-023.
REQ-021 On an IDLE transfer with MAX_BURST=1: rr_ptr SHALL become (candidate+1) mod NUM_REQ, and the FSM SHALL stay in IDLE.
REQ-022 On an IDLE transfer with MAX_BURST>1: owner SHALL become the candidate, beat_cnt SHALL become 1, and the FSM SHALL go to BURST.
REQ-023 In BURST with req_valid[owner]=0, regardless of fifo_full: no transfer, rr_ptr SHALL become (owner+1) mod NUM_REQ, and the FSM SHALL go to IDLE. Other requesters are arbitrated from the next cycle.
REQ-024 On a BURST transfer, beat_cnt SHALL increment; if the new value equals MAX_BURST, rr_ptr SHALL become (owner+1) mod NUM_REQ and the FSM SHALL go to IDLE.
REQ-025 No requester SHALL wait more than (NUM_REQ-1)*MAX_BURST transfers while holding req_valid high.
REQ-026 A requester SHALL hold req_valid and req_data stable until accepted; the arbiter does not check this.
REQ-027 locked SHALL be 1 exactly when the FSM is in BURST.

Reset
REQ-028 Assertion of reset_n=0 SHALL immediately, asynchronously of clk, force: FSM=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
REQ-029 While reset_n=0, req_ready=0, fifo_wr_en=0 and locked=0, regardless of req_valid.
REQ-030 Reset asserted mid-burst SHALL abandon the burst with no partial state retained; after deassertion, arbitration restarts from requester 0.

Verification
REQ-031 Scenario: reset; req_valid=4'b1111 held for 12 cycles; fifo_full=0 -> grant order 0,0,0,0,1,1,1,1,2,2,2,2; locked high from cycle 2 of each burst.
REQ-032 Scenario: only requester 2 valid for 1 beat, then drops -> one write, with fifo_wr_data equal to requester 2's data; rr_ptr=3; next req_valid=4'b1001 is granted to requester 3.
REQ-033 Scenario: mid-burst (beat_cnt=2) fifo_full=1 for 5 cycles -> fifo_wr_en=0 and req_ready=0 for 5 cycles, locked stays 1; remaining 2 beats go to the same owner after full clears.
REQ-034 Scenario: fifo_full=1 while requester 1 is in BURST and drops valid -> release in that cycle; locked=0 in the next cycle; rr_ptr=2.
REQ-035 Scenario: reset_n pulsed low for 3 ns between clock edges during a burst of requester 3 -> outputs go to 0 immediately; after release, req_valid=4'b1010 is granted to requester 1.
REQ-036 Scenario: sweep NUM_REQ=2 with MAX_BURST=1 and both requesters valid -> strict alternation 0,1,0,1; locked is never 1.
